// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: groups the signals between the core, the sequencer and the
// unified memory.
//   master modport : the sequencer. It takes the core requests and memory
//                    responses, and drives the core results and memory requests.
//   slave modport  : the environment (core plus memory) seen from outside.
//   Core side   : inst_ce_i, inst_addr_i, inst_o, data_ce_i, data_we_i,
//                 data_addr_i, data_wdata_i, data_rdata_o, stall_o, err_o
//   Memory side : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i,
//                 mem_ack_i
interface mem_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  inst_ce_i;
  logic [ADDR_WIDTH-1:0] inst_addr_i;
  logic [DATA_WIDTH-1:0] inst_o;
  logic                  data_ce_i;
  logic                  data_we_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  stall_o;
  logic                  err_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport master (
    input  inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i,
           data_wdata_i, mem_rdata_i, mem_ack_i,
    output inst_o, data_rdata_o, stall_o, err_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o
  );

  modport slave (
    output inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i,
           data_wdata_i, mem_rdata_i, mem_ack_i,
    input  inst_o, data_rdata_o, stall_o, err_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: puts the single-cycle core's instruction fetch and its optional
// load/store onto one shared, variable-latency memory port. Accesses run one at
// a time, fetch first. The returned words are held in registers, and the core
// stalls until every access it requested has completed.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_sequencer_if.master (core inst_*/data_* side plus mem_* port)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (busy-cycle limit).
// Optional feature: define MEMSEQ_TIMEOUT_EN to abort a transaction that has
// had no ack after TIMEOUT busy cycles and to set the sticky err_o.
module mem_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  mem_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  // A zero limit would abort every transaction before it could complete.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("mem_sequencer: TIMEOUT must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_i_q, done_i_d;
  logic                  done_d_q, done_d_d;
  logic                  stall_c;
  logic                  fetch_elig_c;
  logic                  data_elig_c;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_hit_c;

  assign cnt_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // The core may advance only once each access it asked for is done.
  assign stall_c      = (bus.inst_ce_i & ~done_i_q) | (bus.data_ce_i & ~done_d_q);
  assign fetch_elig_c = bus.inst_ce_i & ~done_i_q;
  // The data access is decoded from inst_o, so it waits for this cycle's fetch.
  assign data_elig_c  = bus.data_ce_i & ~done_d_q & (done_i_q | ~bus.inst_ce_i);

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    // The done flags clear when the core advances; a completion below overrides this.
    done_i_d = stall_c ? done_i_q : 1'b0;
    done_d_d = stall_c ? done_d_q : 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
    err_d    = err_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_elig_c) begin
          state_d = I_BUSY;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.inst_addr_i;
`ifdef MEMSEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (data_elig_c) begin
          state_d = D_BUSY;
          req_d   = 1'b1;
          we_d    = bus.data_we_i;
          addr_d  = bus.data_addr_i;
          wdata_d = bus.data_wdata_i;
`ifdef MEMSEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      I_BUSY: begin
        if (bus.mem_ack_i) begin
          state_d  = IDLE;
          inst_d   = bus.mem_rdata_i;
          done_i_d = 1'b1;
          req_d    = 1'b0;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (cnt_hit_c) begin
          // Abort: give the core a NOP so it can keep going.
          state_d  = IDLE;
          inst_d   = NOP_INST;
          done_i_d = 1'b1;
          req_d    = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      D_BUSY: begin
        if (bus.mem_ack_i) begin
          state_d  = IDLE;
          if (!we_q) rdata_d = bus.mem_rdata_i;
          done_d_d = 1'b1;
          req_d    = 1'b0;
          we_d     = 1'b0;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (cnt_hit_c) begin
          state_d  = IDLE;
          if (!we_q) rdata_d = '0;
          done_d_d = 1'b1;
          req_d    = 1'b0;
          we_d     = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      inst_q   <= '0;
      rdata_q  <= '0;
      done_i_q <= 1'b0;
      done_d_q <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      inst_q   <= inst_d;
      rdata_q  <= rdata_d;
      done_i_q <= done_i_d;
      done_d_q <= done_d_d;
`ifdef MEMSEQ_TIMEOUT_EN
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.inst_o       = inst_q;
  assign bus.data_rdata_o = rdata_q;
  assign bus.stall_o      = stall_c;
  assign bus.mem_req_o    = req_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
`ifdef MEMSEQ_TIMEOUT_EN
  assign bus.err_o        = err_q;
`else
  assign bus.err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: bench for mem_sequencer. A memory model answers requests
// after a wait count queued per transaction. The expected memory requests and
// core results are queued when each instruction is issued. Monitors pop and
// compare when a request rises or when the core advances.
module tb_mem_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [DW-1:0] rdata;
  } adv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m();

  mem_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  int errors = 0;
  int checks = 0;

  req_t req_q[$];
  adv_t adv_q[$];
  int   wait_q[$];

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rdata_m;
  logic [DW-1:0] last_inst;
  bit            hang;
  bit            inject_ack;
  int            mcnt;
  int            cur_wait;
  bit            have;
  logic          req_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks the request after its queued number of wait cycles.
  always @(posedge clk) begin
    #1;
    if (rst || !m.mem_req_o) begin
      mcnt          = 0;
      have          = 1'b0;
      m.mem_ack_i   = inject_ack;
      m.mem_rdata_i = '0;
    end else begin
      if (!have) begin
        cur_wait = 0;
        if (wait_q.size() > 0) cur_wait = wait_q.pop_front();
        have = 1'b1;
      end
      if (!hang && mcnt == cur_wait) begin
        m.mem_ack_i = 1'b1;
        if (m.mem_we_o) begin
          mem[m.mem_addr_o] = m.mem_wdata_o;
          m.mem_rdata_i     = '0;
        end else if (mem.exists(m.mem_addr_o)) begin
          m.mem_rdata_i = mem[m.mem_addr_o];
        end else begin
          m.mem_rdata_i = '0;
        end
      end else begin
        m.mem_ack_i   = 1'b0;
        m.mem_rdata_i = '0;
      end
      mcnt++;
    end
  end

  // Monitors: a new request and each core advance are compared to the queues.
  always @(negedge clk) begin
    req_t re;
    adv_t ae;
    if (!rst) begin
      if (m.mem_req_o && !req_prev) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          re = req_q.pop_front();
          chk("req_we", 64'(m.mem_we_o), 64'(re.we));
          chk("req_addr", 64'(m.mem_addr_o), 64'(re.addr));
          if (re.we) chk("req_wdata", 64'(m.mem_wdata_o), 64'(re.wdata));
        end
      end
      if ((m.inst_ce_i || m.data_ce_i) && !m.stall_o) begin
        if (adv_q.size() == 0) begin
          chk("adv_unexpected", 64'd1, 64'd0);
        end else begin
          ae = adv_q.pop_front();
          chk("adv_inst", 64'(m.inst_o), 64'(ae.inst));
          chk("adv_rdata", 64'(m.data_rdata_o), 64'(ae.rdata));
        end
      end
    end
    req_prev = m.mem_req_o;
  end

  // One instruction: kind 0 = no data access, 1 = load, 2 = store.
  task automatic run_instr(input logic [AW-1:0] iaddr, input int kind,
                           input logic [AW-1:0] daddr, input logic [DW-1:0] wd,
                           input int iw, input int dw, input logic [DW-1:0] exp_inst,
                           input logic [DW-1:0] exp_rd, input int exp_cpi);
    int cyc;
    wait_q.push_back(iw);
    req_q.push_back('{we: 1'b0, addr: iaddr, wdata: '0});
    if (kind != 0) begin
      wait_q.push_back(dw);
      req_q.push_back('{we: (kind == 2), addr: daddr, wdata: wd});
    end
    if (kind == 1) rdata_m = exp_rd;
    adv_q.push_back('{inst: exp_inst, rdata: rdata_m});
    last_inst = exp_inst;
    @(posedge clk); #1;
    m.inst_ce_i    = 1'b1;
    m.inst_addr_i  = iaddr;
    m.data_ce_i    = (kind != 0);
    m.data_we_i    = (kind == 2);
    m.data_addr_i  = daddr;
    m.data_wdata_i = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (m.stall_o && cyc < 100);
    chk("cpi", 64'(cyc), 64'(exp_cpi));
    @(posedge clk); #1;
    m.inst_ce_i = 1'b0;
    m.data_ce_i = 1'b0;
    m.data_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    hang           = 1'b0;
    inject_ack     = 1'b0;
    req_prev       = 1'b0;
    rdata_m        = '0;
    last_inst      = '0;
    m.inst_ce_i    = 1'b0;
    m.inst_addr_i  = '0;
    m.data_ce_i    = 1'b0;
    m.data_we_i    = 1'b0;
    m.data_addr_i  = '0;
    m.data_wdata_i = '0;
    mem[32'h100]  = 32'h0050_0093;
    mem[32'h104]  = 32'h0000_2083;
    mem[32'h108]  = 32'h0010_2223;
    mem[32'h10C]  = 32'h00A0_0113;
    mem[32'h114]  = 32'h0080_2103;
    mem[32'h118]  = 32'h0020_2423;
    mem[32'h300]  = 32'h0030_0193;
    mem[32'h2000] = 32'hDEAD_BEEF;
    mem[32'h2008] = 32'hCAFE_F00D;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 64'(m.mem_req_o), 64'd0);
    chk("rst_we", 64'(m.mem_we_o), 64'd0);
    chk("rst_inst", 64'(m.inst_o), 64'd0);
    chk("rst_rdata", 64'(m.data_rdata_o), 64'd0);
    chk("rst_err", 64'(m.err_o), 64'd0);
    chk("rst_stall", 64'(m.stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Non-memory instruction, zero-wait: CPI 3.
    run_instr(32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, 3);
    // Load, zero-wait fetch, 2 wait states on data: CPI 7.
    run_instr(32'h104, 1, 32'h2000, 32'h0, 0, 2, 32'h0000_2083, 32'hDEAD_BEEF, 7);
    // Load, zero-wait throughout: CPI 5.
    run_instr(32'h114, 1, 32'h2008, 32'h0, 0, 0, 32'h0080_2103, 32'hCAFE_F00D, 5);
    // Store, zero-wait: CPI 5, load data register untouched.
    run_instr(32'h108, 2, 32'h2004, 32'h1234_5678, 0, 0, 32'h0010_2223, 32'h0, 5);
    chk("store_mem", 64'(mem[32'h2004]), 64'h1234_5678);
    chk("store_we_low", 64'(m.mem_we_o), 64'd0);
    // Store with one wait state on both accesses: CPI 7.
    run_instr(32'h118, 2, 32'h200C, 32'hA5A5_5A5A, 1, 1, 32'h0020_2423, 32'h0, 7);
    chk("store2_mem", 64'(mem[32'h200C]), 64'hA5A5_5A5A);

    // An ack while idle is ignored.
    @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_ack_req", 64'(m.mem_req_o), 64'd0);
    chk("idle_ack_inst", 64'(m.inst_o), 64'(last_inst));
    chk("idle_ack_stall", 64'(m.stall_o), 64'd0);

    // The fetch address changes mid-fetch; the issued address must hold (3 waits: CPI 6).
    fork
      run_instr(32'h10C, 0, 32'h0, 32'h0, 3, 0, 32'h00A0_0113, 32'h0, 6);
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        m.inst_addr_i = 32'h200;
        @(negedge clk);
        chk("busy_addr_hold", 64'(m.mem_addr_o), 64'h10C);
      end
    join

`ifdef MEMSEQ_TIMEOUT_EN
    // A fetch with no ack for 16 busy cycles is aborted: NOP, err set, CPI 18.
    hang = 1'b1;
    run_instr(32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0000_0013, 32'h0, 18);
    hang = 1'b0;
    chk("to_req_low", 64'(m.mem_req_o), 64'd0);
    chk("to_err", 64'(m.err_o), 64'd1);
    run_instr(32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, 3);
    chk("to_err_sticky", 64'(m.err_o), 64'd1);
`else
    chk("err_tied", 64'(m.err_o), 64'd0);
`endif

    // Reset in the middle of a fetch.
    hang = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: '0});
    @(posedge clk); #1;
    m.inst_ce_i   = 1'b1;
    m.inst_addr_i = 32'h300;
    repeat (3) @(posedge clk);
    chk("pre_rst_req", 64'(m.mem_req_o), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_req", 64'(m.mem_req_o), 64'd0);
    chk("midrst_inst", 64'(m.inst_o), 64'd0);
    chk("midrst_err", 64'(m.err_o), 64'd0);
    chk("midrst_rdata", 64'(m.data_rdata_o), 64'd0);
    m.inst_ce_i = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b0;
    hang    = 1'b0;
    rdata_m = '0;
    wait_q.delete();
    @(negedge clk);
    chk("post_rst_req", 64'(m.mem_req_o), 64'd0);
    // A zero-wait fetch taking CPI 3 shows the sequencer restarted from IDLE.
    run_instr(32'h100, 0, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, 3);

    repeat (2) @(posedge clk);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("adv_q_empty", 64'(adv_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
